multiexp_pnt_scl_replay: RTL and testbench
==========================================

// Module: multiexp_pnt_scl_replay
// PURPOSE
//  Upstream feeder for the Fp2 multiexp core. Loads one batch of NUM_IN {scalar, G2 point} pairs (7 FE words each:
//  scalar, x0,x1,y0,y1,z0,z1) into local RAM, then replays the batch as the looping stream the core consumes.
//  Normal mode replays KEY_BITS passes; single-add mode (ctl[0]==1) replays one pass.
//  Replay preserves word order and data, with sop/eop regenerated per pair.
// PARAMETERS
//  DAT_BITS   381  width of one FE word / stream beat
//  CTL_BITS   16   stream ctl width, passed through unmodified
//  KEY_BITS   381  replay passes in normal mode (scalar bit count)
//  MAX_IN     64   max pairs per batch; RAM depth = 7*MAX_IN words
// PORTS
//  i_clk          in   1                    clock
//  i_rst_n        in   1                    asynchronous reset, active-low
//  i_pnt_scl_if   sink DAT_BITS/CTL_BITS    load stream (val,rdy,dat,sop,eop,ctl), 7 beats per pair
//  o_pnt_scl_if   src  DAT_BITS/CTL_BITS    replay stream to multiexp core, 7 beats per pair
//  i_num_in       in   $clog2(MAX_IN+1)     pairs in batch, sampled on first load beat
//  o_busy         out  1                    high from first accepted load beat until last replay beat accepted
//  o_err          out  1                    1-cycle pulse: illegal i_num_in, beat dropped
// BEHAVIOUR
//  Reset (i_rst_n=0, async): state=IDLE; all counters 0; o_pnt_scl_if.val/sop/eop=0, dat=0, ctl=0;
//    i_pnt_scl_if.rdy=0; o_busy=0; o_err=0. RAM contents are not cleared. Reset mid-load or mid-replay aborts
//    the batch; no partial output resumes after release.
//  States:
//    IDLE:   rdy=1. On val&rdy:
//            - if i_num_in==0 or i_num_in>MAX_IN: drop beat, pulse o_err, stay in IDLE.
//            - otherwise latch num_in and ctl, write beat to addr 0, set o_busy, go to LOAD
//              (to REPLAY if num_in*7==1, which cannot occur).
//    LOAD:   rdy=1; each accepted beat goes to addr wr_cnt++.
//            When beat num_in*7-1 is written, rdy drops next cycle and state goes to REPLAY.
//            Input sop/eop are ignored for addressing.
//    REPLAY: rdy=0. Reads addr 0..num_in*7-1 in order; address wraps to 0 and pass_cnt increments
//            after the last word. Passes = (ctl[0] ? 1 : KEY_BITS).
//            When the final beat of the final pass is accepted: go to IDLE, o_busy=0 the next cycle.
//  Output framing: beat index b=addr mod 7; sop=(b==0), eop=(b==6); ctl=latched batch ctl.
//  RAM: 1-cycle registered read. Use a 2-entry output skid/prefetch so that:
//    - with rdy held high, output is 1 beat/cycle, no bubbles, including across pass wrap;
//    - first replay val is asserted at most 2 cycles after REPLAY entry.
//  Handshake: AXI-stream rules. Once val=1, dat/sop/eop/ctl hold stable until val&rdy.
//    val never drops without a transfer. Any rdy pattern is tolerated with no loss or duplication.
//  pass_cnt width is $clog2(KEY_BITS+1). No wrap beyond the pass count; the exact beat total
//    is passes*num_in*7.
//  Load and replay never overlap: a new batch is accepted only in IDLE.
// TESTING
//  1 KEY_BITS=4, num_in=2, ctl=0, load dat=0..13 -> 56 out beats: 0..13 four times; sop at
//    beats 0,7,14,...; eop at 6,13,20,...; o_busy falls after beat 55.
//  2 ctl[0]=1, num_in=1, dat=A0..A6 -> exactly 7 beats A0..A6, sop on A0, eop on A6, ctl=1 on all; then IDLE.
//  3 Case 1 with random 50% o rdy and gappy i val -> identical sequence; dat stable while val&~rdy;
//    scoreboard count = 56.
//  4 num_in=0, then num_in=MAX_IN+1, one beat each -> o_err pulses twice, no output, o_busy stays 0;
//    next valid batch replays correctly.
//  5 num_in=MAX_IN, rdy=1 -> last word comes from addr 7*MAX_IN-1; zero bubbles at pass wrap;
//    val within 2 cycles of REPLAY entry.
//  6 Drop i_rst_n mid pass 2 of case 1 -> val=0, o_busy=0 immediately; after release a new
//    num_in=1 batch replays 4 passes of its 7 words only.

Source files
------------

// File: rtl/multiexp_pnt_scl_replay_if.sv
// Stream bundle shared by the load side and the replay side of the point/scalar feeder.
//
// Ports (signals):
//   val  master->slave  beat present
//   rdy  slave->master  sink can take the beat
//   dat  master->slave  one FE word
//   sop  master->slave  first beat of a pair
//   eop  master->slave  last (7th) beat of a pair
//   ctl  master->slave  side-band control
//
// Handshake: a beat transfers on a rising clock edge where val && rdy. Once the master raises
// val, it keeps val, dat, sop, eop and ctl stable until that transfer. val never drops without
// a transfer. rdy may change on any cycle.
interface multiexp_pnt_scl_replay_if #(
  parameter int DAT_BITS = 381,
  parameter int CTL_BITS = 16
);
  logic                val;
  logic                rdy;
  logic [DAT_BITS-1:0] dat;
  logic                sop;
  logic                eop;
  logic [CTL_BITS-1:0] ctl;

  modport master (output val, dat, sop, eop, ctl, input rdy);
  modport slave  (input val, dat, sop, eop, ctl, output rdy);
endinterface

// File: rtl/multiexp_pnt_scl_replay.sv
// Feeder for the Fp2 multiexp core. Loads one batch of num_in pairs (7 words each: scalar,
// x0, x1, y0, y1, z0, z1) into local RAM and then replays it as a looping stream: KEY_BITS
// passes normally, a single pass when ctl[0] of the batch is set.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_pnt_scl_if    load stream sink, 7 beats per pair
//   o_pnt_scl_if    replay stream source, sop/eop regenerated per pair, ctl = batch ctl
//   i_num_in        pairs in the batch, sampled on the first load beat
//   o_busy          high from first accepted load beat until last replay beat accepted
//   o_err           one-cycle pulse when a first beat arrives with an illegal i_num_in
//   o_state         FSM state (0 idle, 1 load, 2 replay) for observation
module multiexp_pnt_scl_replay #(
  parameter int DAT_BITS = 381,
  parameter int CTL_BITS = 16,
  parameter int KEY_BITS = 381,
  parameter int MAX_IN   = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  multiexp_pnt_scl_replay_if.slave     i_pnt_scl_if,
  multiexp_pnt_scl_replay_if.master    o_pnt_scl_if,
  input  logic [$clog2(MAX_IN+1)-1:0]  i_num_in,
  output logic                         o_busy,
  output logic                         o_err,
  output logic [1:0]                   o_state
);

  localparam int DEPTH = 7 * MAX_IN;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(KEY_BITS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] REPLAY = 2'd2;

  logic [DAT_BITS-1:0] mem [DEPTH];

  logic [1:0]          state;
  logic                in_rdy;
  logic                busy;
  logic                err;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       last_addr;
  logic [CTL_BITS-1:0] ctl_q;

  // Read side: rd_addr/beat/pass_cnt track the next word to fetch, issue_done marks that the
  // final word of the final pass has been fetched.
  logic [AW-1:0]       rd_addr;
  logic [2:0]          beat;
  logic [PW-1:0]       pass_cnt;
  logic                issue_done;

  // Two-entry output buffer. The RAM read lands directly in an entry, so an entry is
  // allocated in the same cycle the read is issued.
  logic [DAT_BITS-1:0] e_dat [2];
  logic [1:0]          e_sop;
  logic [1:0]          e_eop;
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  logic in_fire, num_ok, wr_en, pop, issue, last_pass, last_issue, done;
  logic [AW-1:0] wr_a;

  assign in_fire    = i_pnt_scl_if.val && in_rdy;
  assign num_ok     = (i_num_in != '0) && (int'(i_num_in) <= MAX_IN);
  assign wr_en      = in_fire && ((state == LOAD) || ((state == IDLE) && num_ok));
  assign wr_a       = (state == IDLE) ? '0 : wr_addr;

  assign pop        = (count != 2'd0) && o_pnt_scl_if.rdy;
  // Fetch whenever a slot is free after this cycle's pop: keeps one beat per cycle.
  assign issue      = (state == REPLAY) && !issue_done && ((count != 2'd2) || pop);
  assign last_pass  = ctl_q[0] ? (pass_cnt == '0) : (pass_cnt == PW'(KEY_BITS - 1));
  assign last_issue = (rd_addr == last_addr) && last_pass;
  // Everything fetched and the last buffered beat leaves now.
  assign done       = (state == REPLAY) && issue_done && pop && (count == 2'd1);

  assign i_pnt_scl_if.rdy = in_rdy;
  assign o_pnt_scl_if.val = (count != 2'd0);
  assign o_pnt_scl_if.dat = e_dat[rd_ptr];
  assign o_pnt_scl_if.sop = e_sop[rd_ptr];
  assign o_pnt_scl_if.eop = e_eop[rd_ptr];
  assign o_pnt_scl_if.ctl = ctl_q;
  assign o_busy           = busy;
  assign o_err            = err;
  assign o_state          = state;

  // RAM is not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_a] <= i_pnt_scl_if.dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      in_rdy     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      wr_addr    <= '0;
      last_addr  <= '0;
      ctl_q      <= '0;
      rd_addr    <= '0;
      beat       <= '0;
      pass_cnt   <= '0;
      issue_done <= 1'b0;
      e_dat[0]   <= '0;
      e_dat[1]   <= '0;
      e_sop      <= '0;
      e_eop      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          in_rdy <= 1'b1;
          if (in_fire) begin
            if (!num_ok) begin
              err <= 1'b1;
            end else begin
              ctl_q     <= i_pnt_scl_if.ctl;
              last_addr <= AW'(7 * int'(i_num_in) - 1);
              wr_addr   <= AW'(1);
              busy      <= 1'b1;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_fire) begin
            wr_addr <= wr_addr + AW'(1);
            if (wr_addr == last_addr) begin
              in_rdy <= 1'b0;
              state  <= REPLAY;
            end
          end
        end
        REPLAY: begin
          if (done) begin
            state   <= IDLE;
            busy    <= 1'b0;
            in_rdy  <= 1'b1;
            wr_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        e_dat[wr_ptr] <= mem[rd_addr];
        e_sop[wr_ptr] <= (beat == 3'd0);
        e_eop[wr_ptr] <= (beat == 3'd6);
        wr_ptr        <= ~wr_ptr;
        beat          <= (beat == 3'd6) ? 3'd0 : beat + 3'd1;
        if (rd_addr == last_addr) begin
          rd_addr  <= '0;
          pass_cnt <= pass_cnt + PW'(1);
        end else begin
          rd_addr <= rd_addr + AW'(1);
        end
        if (last_issue) issue_done <= 1'b1;
      end
      if (done) begin
        issue_done <= 1'b0;
        rd_addr    <= '0;
        pass_cnt   <= '0;
        beat       <= '0;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, issue} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_multiexp_pnt_scl_replay.sv
module tb_multiexp_pnt_scl_replay;
  localparam int DAT_BITS = 32;
  localparam int CTL_BITS = 16;
  localparam int KEY_BITS = 4;
  localparam int MAX_IN   = 4;
  localparam int NUM_W    = $clog2(MAX_IN + 1);
  localparam int EW       = DAT_BITS + 2 + CTL_BITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NUM_W-1:0] num_in;
  logic             busy;
  logic             err;
  logic [1:0]       state;

  multiexp_pnt_scl_replay_if #(.DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS)) in_if ();
  multiexp_pnt_scl_replay_if #(.DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS)) out_if ();

  multiexp_pnt_scl_replay #(
    .DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS), .KEY_BITS(KEY_BITS), .MAX_IN(MAX_IN)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_pnt_scl_if(in_if.slave),
    .o_pnt_scl_if(out_if.master),
    .i_num_in(num_in),
    .o_busy(busy),
    .o_err(err),
    .o_state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DAT_BITS-1:0] words[$];
  logic [EW-1:0]       exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: the replay stream is the loaded words, in order, repeated per pass,
  // with sop on the first and eop on the last word of every pair
  task automatic build_expect(input int n, input logic [CTL_BITS-1:0] c);
    int passes = c[0] ? 1 : KEY_BITS;
    exp_q.delete();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 7 * n; i++)
        exp_q.push_back({words[i], (i % 7) == 0, (i % 7) == 6, c});
  endtask

  // driver: load stream, optional idle gaps between beats
  task automatic load_batch(input int n, input logic [CTL_BITS-1:0] c, input bit gappy);
    int w;
    for (int k = 0; k < 7 * n; k++) begin
      if (gappy) begin
        repeat ($urandom_range(0, 2)) begin
          in_if.val = 1'b0;
          in_if.dat = DAT_BITS'($urandom);
          @(negedge clk);
        end
      end
      in_if.val = 1'b1;
      in_if.dat = words[k];
      in_if.sop = (k % 7) == 0;
      in_if.eop = (k % 7) == 6;
      in_if.ctl = c;
      num_in    = (k == 0) ? NUM_W'(n) : NUM_W'($urandom);
      w = 0;
      while (!in_if.rdy && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("load_rdy", 64'(in_if.rdy), 64'd1);
      @(negedge clk);
      if (k == 0) check("busy_after_first_load", 64'(busy), 64'd1);
    end
    in_if.val = 1'b0;
  endtask

  // consumer + scoreboard: random or constant rdy, stops after stop_after transfers
  task automatic drain(input int n_beats, input bit rnd, input int stop_after, output int got);
    logic [EW-1:0] cur, held, e;
    bit stalled, seen, r;
    int wait_val, bubbles;
    got = 0; stalled = 0; seen = 0; wait_val = 0; bubbles = 0; held = '0;
    for (int cyc = 0; cyc < 4000 && got < stop_after; cyc++) begin
      cur = {out_if.dat, out_if.sop, out_if.eop, out_if.ctl};
      if (stalled) begin
        check("hold_val", 64'(out_if.val), 64'd1);
        check("hold_beat", 64'(cur), 64'(held));
      end
      if (out_if.val) seen = 1;
      else if (!seen) wait_val++;
      else bubbles++;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_if.rdy = r;
      if (out_if.val && r) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check($sformatf("beat%0d", got), 64'(cur), 64'(e));
        if (got == n_beats - 1) check("busy_last_beat", 64'(busy), 64'd1);
        got++;
        stalled = 0;
      end else begin
        stalled = out_if.val;
      end
      held = cur;
      @(negedge clk);
    end
    check("first_val_latency_le2", 64'(wait_val <= 2), 64'd1);
    if (!rnd) check("bubbles", 64'(bubbles), 64'd0);
    if (stop_after == n_beats) begin
      out_if.rdy = 1'b1;
      check("beat_count", 64'(got), 64'(n_beats));
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      check("busy_after_done", 64'(busy), 64'd0);
      check("state_after_done", 64'(state), 64'd0);
      bubbles = 0;
      repeat (6) begin
        if (out_if.val) bubbles++;
        @(negedge clk);
      end
      check("no_extra_beats", 64'(bubbles), 64'd0);
    end
  endtask

  initial begin
    int got;
    in_if.val = 1'b0; in_if.dat = '0; in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.ctl = '0;
    out_if.rdy = 1'b0;
    num_in = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_oval", 64'(out_if.val), 64'd0);
    check("rst_irdy", 64'(in_if.rdy), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_beat", 64'({out_if.dat, out_if.sop, out_if.eop, out_if.ctl}), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // case 1: num_in=2, dat 0..13, ctl=0, 4 passes
    words.delete();
    for (int i = 0; i < 14; i++) words.push_back(DAT_BITS'(i));
    build_expect(2, '0);
    load_batch(2, '0, 0);
    drain(56, 0, 56, got);

    // case 2: single-add mode, one pair
    words.delete();
    for (int i = 0; i < 7; i++) words.push_back(DAT_BITS'(32'hA0 + i));
    build_expect(1, 16'h0001);
    load_batch(1, 16'h0001, 0);
    drain(7, 0, 7, got);

    // case 3: case 1 with gappy input, random output rdy, ctl bits passed through
    words.delete();
    for (int i = 0; i < 14; i++) words.push_back(DAT_BITS'(i));
    build_expect(2, 16'h5A5A);
    load_batch(2, 16'h5A5A, 1);
    drain(56, 1, 56, got);

    // case 4: illegal batch sizes are dropped with an error pulse
    for (int t = 0; t < 2; t++) begin
      in_if.val = 1'b1;
      in_if.dat = DAT_BITS'($urandom);
      num_in    = (t == 0) ? NUM_W'(0) : NUM_W'(MAX_IN + 1);
      @(negedge clk);
      in_if.val = 1'b0;
      check($sformatf("err_pulse%0d", t), 64'(err), 64'd1);
      check($sformatf("err_busy%0d", t), 64'(busy), 64'd0);
      check($sformatf("err_state%0d", t), 64'(state), 64'd0);
      @(negedge clk);
      check($sformatf("err_clear%0d", t), 64'(err), 64'd0);
      check($sformatf("err_oval%0d", t), 64'(out_if.val), 64'd0);
    end
    words.delete();
    for (int i = 0; i < 7; i++) words.push_back(DAT_BITS'($urandom));
    build_expect(1, 16'h0002);
    load_batch(1, 16'h0002, 0);
    drain(28, 0, 28, got);

    // case 5: full batch, random data, rdy held high
    words.delete();
    for (int i = 0; i < 7 * MAX_IN; i++) words.push_back(DAT_BITS'($urandom));
    build_expect(MAX_IN, '0);
    load_batch(MAX_IN, '0, 0);
    drain(7 * MAX_IN * KEY_BITS, 0, 7 * MAX_IN * KEY_BITS, got);

    // case 6: reset in the middle of pass 2, then a fresh one-pair batch
    words.delete();
    for (int i = 0; i < 14; i++) words.push_back(DAT_BITS'(i));
    build_expect(2, '0);
    load_batch(2, '0, 0);
    drain(56, 0, 20, got);
    rst_n = 1'b0;
    #1;
    check("midrst_oval", 64'(out_if.val), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_irdy", 64'(in_if.rdy), 64'd0);
    check("midrst_state", 64'(state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_oval", 64'(out_if.val), 64'd0);
    words.delete();
    for (int i = 0; i < 7; i++) words.push_back(DAT_BITS'($urandom));
    build_expect(1, '0);
    load_batch(1, '0, 0);
    drain(28, 1, 28, got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
